// File: rtl/ether_tx_scheduler_if.sv
// rtl/ether_tx_scheduler_if.sv - requester, frame generator and status signals of the tx scheduler
interface ether_tx_scheduler_if;
  logic       req_a;
  logic [6:0] data_a;
  logic       req_b;
  logic [6:0] data_b;
  logic       gnt_a;
  logic       gnt_b;
  logic       done_a;
  logic       done_b;
  logic       tx_start;
  logic       tx_id;
  logic [6:0] tx_data;
  logic       tx_en_mon;
  logic       busy;
  logic       err_timeout;

  // master is the scheduler, slave is the requesters plus frame generator side
  modport master (
    input  req_a, data_a, req_b, data_b, tx_en_mon,
    output gnt_a, gnt_b, done_a, done_b, tx_start, tx_id, tx_data, busy, err_timeout
  );

  modport slave (
    output req_a, data_a, req_b, data_b, tx_en_mon,
    input  gnt_a, gnt_b, done_a, done_b, tx_start, tx_id, tx_data, busy, err_timeout
  );
endinterface

// File: rtl/ether_tx_scheduler.sv
// rtl/ether_tx_scheduler.sv - round-robin A/B plus periodic auto frame scheduler for one tx datapath
module ether_tx_scheduler #(
  parameter int IFG_CYCLES    = 12,
  parameter int INTERVAL      = 10000,
  parameter int AUTO_EN       = 1,
  parameter int START_TIMEOUT = 16,
  parameter int MAX_FRAME     = 2047
) (
  input logic                  clk_125,
  input logic                  rst,
  ether_tx_scheduler_if.master bus
);

  localparam int MAX_ST   = (MAX_FRAME > START_TIMEOUT) ? MAX_FRAME : START_TIMEOUT;
  localparam int CNT_MAX  = (MAX_ST > IFG_CYCLES) ? MAX_ST : IFG_CYCLES;
  localparam int CW       = $clog2(CNT_MAX + 1);
  localparam int IW       = $clog2(INTERVAL);

  typedef enum logic [1:0] {IDLE, WAIT_EN, WAIT_END, GAP} state_t;
  typedef enum logic [1:0] {OWN_A, OWN_B, OWN_AUTO} owner_t;

  state_t        state_q, state_d;
  owner_t        owner_q, owner_d;
  logic          last_b_q, last_b_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] ival_q;
  logic          auto_pending_q;
  logic          wrap;
  logic          auto_launch;

  logic          gnt_a_q, gnt_a_d;
  logic          gnt_b_q, gnt_b_d;
  logic          done_a_q, done_a_d;
  logic          done_b_q, done_b_d;
  logic          start_q, start_d;
  logic          err_q, err_d;
  logic          id_q, id_d;
  logic [6:0]    data_q, data_d;
  logic          busy_q;

  assign wrap = (ival_q == IW'(INTERVAL - 1));

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_b_d    = last_b_q;
    cnt_d       = cnt_q;
    id_d        = id_q;
    data_d      = data_q;
    gnt_a_d     = 1'b0;
    gnt_b_d     = 1'b0;
    done_a_d    = 1'b0;
    done_b_d    = 1'b0;
    start_d     = 1'b0;
    err_d       = 1'b0;
    auto_launch = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        // A wins alone, or on a tie when B was served last
        if (bus.req_a && (!bus.req_b || last_b_q)) begin
          gnt_a_d  = 1'b1;
          start_d  = 1'b1;
          id_d     = 1'b0;
          data_d   = bus.data_a;
          owner_d  = OWN_A;
          last_b_d = 1'b0;
          state_d  = WAIT_EN;
        end else if (bus.req_b) begin
          gnt_b_d  = 1'b1;
          start_d  = 1'b1;
          id_d     = 1'b1;
          data_d   = bus.data_b;
          owner_d  = OWN_B;
          last_b_d = 1'b1;
          state_d  = WAIT_EN;
        end else if (auto_pending_q) begin
          auto_launch = 1'b1;
          start_d     = 1'b1;
          id_d        = 1'b0;
          data_d      = 7'd0;
          owner_d     = OWN_AUTO;
          state_d     = WAIT_EN;
        end
      end

      WAIT_EN: begin
        if (bus.tx_en_mon) begin
          cnt_d   = '0;
          state_d = WAIT_END;
        end else if (cnt_q == CW'(START_TIMEOUT - 1)) begin
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = GAP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      WAIT_END: begin
        if (!bus.tx_en_mon) begin
          done_a_d = (owner_q == OWN_A);
          done_b_d = (owner_q == OWN_B);
          cnt_d    = '0;
          state_d  = GAP;
        end else if (cnt_q == CW'(MAX_FRAME - 1)) begin
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = GAP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      GAP: begin
        if (cnt_q == CW'(IFG_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_125) begin
    if (rst) begin
      state_q  <= IDLE;
      owner_q  <= OWN_AUTO;
      last_b_q <= 1'b1;
      cnt_q    <= '0;
      gnt_a_q  <= 1'b0;
      gnt_b_q  <= 1'b0;
      done_a_q <= 1'b0;
      done_b_q <= 1'b0;
      start_q  <= 1'b0;
      err_q    <= 1'b0;
      id_q     <= 1'b0;
      data_q   <= 7'd0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      last_b_q <= last_b_d;
      cnt_q    <= cnt_d;
      gnt_a_q  <= gnt_a_d;
      gnt_b_q  <= gnt_b_d;
      done_a_q <= done_a_d;
      done_b_q <= done_b_d;
      start_q  <= start_d;
      err_q    <= err_d;
      id_q     <= id_d;
      data_q   <= data_d;
      busy_q   <= (state_d != IDLE);
    end
  end

  // a wrap on the launch cycle re-arms the pending flag, so only one auto frame is ever queued
  always_ff @(posedge clk_125) begin
    if (rst) begin
      ival_q         <= '0;
      auto_pending_q <= 1'b0;
    end else begin
      ival_q <= wrap ? '0 : ival_q + 1'b1;
      if (wrap && (AUTO_EN != 0)) begin
        auto_pending_q <= 1'b1;
      end else if (auto_launch) begin
        auto_pending_q <= 1'b0;
      end
    end
  end

  assign bus.gnt_a       = gnt_a_q;
  assign bus.gnt_b       = gnt_b_q;
  assign bus.done_a      = done_a_q;
  assign bus.done_b      = done_b_q;
  assign bus.tx_start    = start_q;
  assign bus.tx_id       = id_q;
  assign bus.tx_data     = data_q;
  assign bus.busy        = busy_q;
  assign bus.err_timeout = err_q;

endmodule

// File: tb/tb_ether_tx_scheduler.sv
// tb/tb_ether_tx_scheduler.sv - directed/random bench: manual-only instance and auto-frame instance
`timescale 1ns/1ps
module tb_ether_tx_scheduler;
  localparam int IFG  = 12;
  localparam int STO  = 16;
  localparam int MAXF = 100;
  localparam int IVL  = 100;

  logic clk = 1'b0;
  always #4 clk = ~clk;

  logic rst_m;
  logic rst_a;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  ether_tx_scheduler_if m_if ();
  ether_tx_scheduler_if a_if ();

  ether_tx_scheduler #(.IFG_CYCLES(IFG), .INTERVAL(10000), .AUTO_EN(0),
                       .START_TIMEOUT(STO), .MAX_FRAME(MAXF))
    u_m (.clk_125(clk), .rst(rst_m), .bus(m_if));

  ether_tx_scheduler #(.IFG_CYCLES(IFG), .INTERVAL(IVL), .AUTO_EN(1),
                       .START_TIMEOUT(STO), .MAX_FRAME(2047))
    u_a (.clk_125(clk), .rst(rst_a), .bus(a_if));

  // event logs, timestamps in cyc units
  int m_st_t[$], m_st_own[$], m_st_id[$], m_st_dat[$];
  int m_done_t[$], m_done_who[$], m_err_t[$], m_idle_t[$], m_fall_t[$];
  int a_st_t[$], a_st_own[$], a_st_id[$], a_st_dat[$];
  int a_done_t[$], a_done_who[$], a_err_t[$], a_fall_t[$];
  int m_viol = 0;
  int a_viol = 0;

  logic       m_busy_prev = 1'b0;
  logic [6:0] m_dat_prev  = 7'd0;
  always @(negedge clk) begin
    if (rst_m) begin
      m_busy_prev = 1'b0;
      m_dat_prev  = 7'd0;
    end else begin
      if (m_if.tx_start) begin
        m_st_t.push_back(cyc);
        m_st_own.push_back(int'({m_if.gnt_b, m_if.gnt_a}));
        m_st_id.push_back(int'(m_if.tx_id));
        m_st_dat.push_back(int'(m_if.tx_data));
      end
      if ((m_if.gnt_a && m_if.gnt_b) || ((m_if.gnt_a || m_if.gnt_b) && !m_if.tx_start)) m_viol++;
      if (m_if.done_a && m_if.done_b) m_viol++;
      if (m_if.tx_data !== m_dat_prev && !m_if.tx_start) m_viol++;
      if (m_if.done_a || m_if.done_b) begin
        m_done_t.push_back(cyc);
        m_done_who.push_back(int'({m_if.done_b, m_if.done_a}));
      end
      if (m_if.err_timeout) m_err_t.push_back(cyc);
      if (m_busy_prev && !m_if.busy) m_idle_t.push_back(cyc);
      m_busy_prev = m_if.busy;
      m_dat_prev  = m_if.tx_data;
    end
  end

  logic [6:0] a_dat_prev = 7'd0;
  always @(negedge clk) begin
    if (rst_a) begin
      a_dat_prev = 7'd0;
    end else begin
      if (a_if.tx_start) begin
        a_st_t.push_back(cyc);
        a_st_own.push_back(int'({a_if.gnt_b, a_if.gnt_a}));
        a_st_id.push_back(int'(a_if.tx_id));
        a_st_dat.push_back(int'(a_if.tx_data));
      end
      if ((a_if.gnt_a && a_if.gnt_b) || ((a_if.gnt_a || a_if.gnt_b) && !a_if.tx_start)) a_viol++;
      if (a_if.tx_data !== a_dat_prev && !a_if.tx_start) a_viol++;
      if (a_if.done_a || a_if.done_b) begin
        a_done_t.push_back(cyc);
        a_done_who.push_back(int'({a_if.done_b, a_if.done_a}));
      end
      if (a_if.err_timeout) a_err_t.push_back(cyc);
      a_dat_prev = a_if.tx_data;
    end
  end

  // frame generator models: tx_en rises dly cycles after tx_start and stays high len cycles
  int   m_dly = 3, m_len = 64;
  logic m_gen_on = 1'b1;
  logic m_kill   = 1'b0;
  initial begin
    m_if.tx_en_mon = 1'b0;
    forever begin
      @(posedge clk); #2;
      if (m_if.tx_start && m_gen_on) begin
        repeat (m_dly) @(posedge clk);
        #2;
        m_if.tx_en_mon = 1'b1;
        for (int i = 0; i < m_len && !m_kill; i++) begin
          @(posedge clk); #2;
        end
        m_if.tx_en_mon = 1'b0;
        if (!m_kill) m_fall_t.push_back(cyc);
      end
    end
  end

  initial begin
    a_if.tx_en_mon = 1'b0;
    forever begin
      @(posedge clk); #2;
      if (a_if.tx_start) begin
        repeat (2) @(posedge clk);
        #2;
        a_if.tx_en_mon = 1'b1;
        repeat (20) @(posedge clk);
        #2;
        a_if.tx_en_mon = 1'b0;
        a_fall_t.push_back(cyc);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int qsz(input int sel);
    case (sel)
      0:       return m_st_t.size();
      1:       return m_idle_t.size();
      2:       return m_fall_t.size();
      default: return a_st_t.size();
    endcase
  endfunction

  task automatic wait_q(input int sel, input int n, input int budget, input string tag);
    int k = 0;
    while (qsz(sel) < n && k < budget) begin
      tick();
      k++;
    end
    chk(tag, qsz(sel) >= n, 1);
  endtask

  initial begin
    int da, db, t0, bs, bd, be, bi, bf, last_b, w;
    rst_m = 1'b1;
    rst_a = 1'b1;
    m_if.req_a = 1'b0; m_if.req_b = 1'b0; m_if.data_a = 7'd0; m_if.data_b = 7'd0;
    a_if.req_a = 1'b0; a_if.req_b = 1'b0; a_if.data_a = 7'd0; a_if.data_b = 7'd0;
    repeat (3) tick();

    chk("rst_busy", m_if.busy, 0);
    chk("rst_tx_id", m_if.tx_id, 0);
    chk("rst_tx_data", m_if.tx_data, 0);
    chk("rst_pulses", {m_if.tx_start, m_if.gnt_a, m_if.gnt_b, m_if.done_a, m_if.done_b, m_if.err_timeout}, 0);
    chk("rst_auto_inst", {a_if.busy, a_if.tx_start, a_if.tx_data}, 0);
    rst_m = 1'b0;
    tick();

    // single requester A, fixed payload
    bs = m_st_t.size(); bd = m_done_t.size(); be = m_err_t.size(); bi = m_idle_t.size(); bf = m_fall_t.size();
    m_dly = 3; m_len = 64;
    m_if.data_a = 7'h2A;
    m_if.req_a  = 1'b1;
    wait_q(0, bs + 1, 10, "t1_wait_start");
    m_if.req_a = 1'b0;
    wait_q(1, bi + 1, 200, "t1_wait_idle");
    if (m_st_t.size() > bs && m_idle_t.size() > bi && m_fall_t.size() > bf && m_done_t.size() > bd) begin
      chk("t1_starts", m_st_t.size() - bs, 1);
      chk("t1_owner", m_st_own[bs], 1);
      chk("t1_tx_id", m_st_id[bs], 0);
      chk("t1_tx_data", m_st_dat[bs], 'h2A);
      chk("t1_done_who", m_done_who[bd], 1);
      chk("t1_done_time", m_done_t[bd], m_fall_t[bf] + 1);
      chk("t1_busy_low_time", m_idle_t[bi], m_fall_t[bf] + IFG + 1);
    end else begin
      chk("t1_events_present", 0, 1);
    end
    chk("t1_no_err", m_err_t.size() - be, 0);

    // both requesters held over three frames
    rst_m = 1'b1; tick(); rst_m = 1'b0; tick();
    bs = m_st_t.size(); bd = m_done_t.size(); be = m_err_t.size(); bi = m_idle_t.size(); bf = m_fall_t.size();
    da = $urandom_range(0, 127); db = $urandom_range(0, 127);
    m_dly = $urandom_range(1, 6); m_len = $urandom_range(8, 40);
    m_if.data_a = 7'(da); m_if.data_b = 7'(db);
    m_if.req_a = 1'b1; m_if.req_b = 1'b1;
    wait_q(0, bs + 3, 400, "t2_wait_starts");
    m_if.req_a = 1'b0; m_if.req_b = 1'b0;
    wait_q(1, bi + 3, 300, "t2_wait_idle");
    last_b = 1;
    for (int k = 0; k < 3; k++) begin
      w = last_b ? 1 : 2;
      last_b = (w == 2) ? 1 : 0;
      if (m_st_t.size() > bs + k && m_done_t.size() > bd + k && m_fall_t.size() > bf + k) begin
        chk($sformatf("t2_owner%0d", k), m_st_own[bs + k], w);
        chk($sformatf("t2_tx_id%0d", k), m_st_id[bs + k], (w == 2) ? 1 : 0);
        chk($sformatf("t2_tx_data%0d", k), m_st_dat[bs + k], (w == 1) ? da : db);
        chk($sformatf("t2_done_who%0d", k), m_done_who[bd + k], w);
        chk($sformatf("t2_done_time%0d", k), m_done_t[bd + k], m_fall_t[bf + k] + 1);
        if (k > 0) chk($sformatf("t2_relaunch%0d", k), m_st_t[bs + k], m_fall_t[bf + k - 1] + IFG + 2);
      end else begin
        chk($sformatf("t2_events%0d", k), 0, 1);
      end
    end
    chk("t2_no_err", m_err_t.size() - be, 0);

    // generator never answers: start timeout
    bs = m_st_t.size(); bd = m_done_t.size(); be = m_err_t.size(); bi = m_idle_t.size();
    m_gen_on = 1'b0;
    db = $urandom_range(0, 127);
    m_if.data_b = 7'(db); m_if.req_b = 1'b1;
    wait_q(0, bs + 1, 10, "t3_wait_start");
    m_if.req_b = 1'b0;
    wait_q(1, bi + 1, 80, "t3_wait_idle");
    if (m_st_t.size() > bs && m_err_t.size() > be && m_idle_t.size() > bi) begin
      chk("t3_err_time", m_err_t[be], m_st_t[bs] + STO);
      chk("t3_idle_time", m_idle_t[bi], m_st_t[bs] + STO + IFG);
      chk("t3_tx_id", m_st_id[bs], 1);
    end else begin
      chk("t3_events_present", 0, 1);
    end
    chk("t3_no_done", m_done_t.size() - bd, 0);
    m_gen_on = 1'b1;

    // tx_en stuck high: frame timeout
    bs = m_st_t.size(); bd = m_done_t.size(); be = m_err_t.size(); bi = m_idle_t.size(); bf = m_fall_t.size();
    m_dly = 2; m_len = 150;
    m_if.req_a = 1'b1;
    wait_q(0, bs + 1, 10, "t3b_wait_start");
    m_if.req_a = 1'b0;
    wait_q(1, bi + 1, 200, "t3b_wait_idle");
    if (m_st_t.size() > bs && m_err_t.size() > be && m_idle_t.size() > bi) begin
      chk("t3b_err_time", m_err_t[be], m_st_t[bs] + 2 + MAXF + 1);
      chk("t3b_idle_time", m_idle_t[bi], m_st_t[bs] + 2 + MAXF + 1 + IFG);
    end else begin
      chk("t3b_events_present", 0, 1);
    end
    wait_q(2, bf + 1, 200, "t3b_wait_fall");
    chk("t3b_no_done", m_done_t.size() - bd, 0);

    // reset in the middle of a frame, then a lone B request
    bs = m_st_t.size(); bd = m_done_t.size(); be = m_err_t.size();
    m_dly = 3; m_len = 80;
    m_if.req_a = 1'b1;
    wait_q(0, bs + 1, 10, "t4_wait_start");
    m_if.req_a = 1'b0;
    repeat (20) tick();
    chk("t4_busy_before_rst", m_if.busy, 1);
    m_kill = 1'b1;
    rst_m  = 1'b1;
    tick();
    chk("t4_rst_busy", m_if.busy, 0);
    chk("t4_rst_pulses", {m_if.tx_start, m_if.gnt_a, m_if.gnt_b, m_if.done_a, m_if.done_b, m_if.err_timeout}, 0);
    rst_m = 1'b0;
    repeat (3) tick();
    m_kill = 1'b0;
    chk("t4_no_done_after_rst", m_done_t.size() - bd, 0);
    chk("t4_no_err_after_rst", m_err_t.size() - be, 0);
    bs = m_st_t.size(); bd = m_done_t.size(); bi = m_idle_t.size(); bf = m_fall_t.size();
    m_len = 10;
    db = $urandom_range(0, 127);
    m_if.data_b = 7'(db); m_if.req_b = 1'b1;
    wait_q(0, bs + 1, 10, "t4_wait_start_b");
    m_if.req_b = 1'b0;
    wait_q(1, bi + 1, 100, "t4_wait_idle_b");
    if (m_st_t.size() > bs && m_done_t.size() > bd) begin
      chk("t4_owner_b", m_st_own[bs], 2);
      chk("t4_tx_id_b", m_st_id[bs], 1);
      chk("t4_tx_data_b", m_st_dat[bs], db);
      chk("t4_done_who_b", m_done_who[bd], 2);
    end else begin
      chk("t4_events_present", 0, 1);
    end
    chk("m_protocol_violations", m_viol, 0);

    // auto instance: periodic frames, then a request racing a pending auto frame
    rst_a = 1'b0;
    t0 = cyc;
    wait_q(3, 3, 400, "t5_wait_autos");
    while (cyc < t0 + 400) tick();
    da = $urandom_range(1, 127);
    a_if.data_a = 7'(da); a_if.req_a = 1'b1;
    wait_q(3, 4, 5, "t6_wait_gnt_a");
    a_if.req_a = 1'b0;
    wait_q(3, 6, 200, "t6_wait_autos");
    if (a_st_t.size() >= 6 && a_fall_t.size() >= 4 && a_done_t.size() >= 1) begin
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("t5_auto_time%0d", k), a_st_t[k], t0 + IVL * (k + 1) + 1);
        chk($sformatf("t5_auto_owner%0d", k), a_st_own[k], 0);
        chk($sformatf("t5_auto_data%0d", k), a_st_dat[k], 0);
      end
      chk("t6_a_time", a_st_t[3], t0 + 4 * IVL + 1);
      chk("t6_a_owner", a_st_own[3], 1);
      chk("t6_a_data", a_st_dat[3], da);
      chk("t6_auto_after_gap", a_st_t[4], a_fall_t[3] + IFG + 2);
      chk("t6_auto_id", a_st_id[4], 0);
      chk("t6_auto_data", a_st_dat[4], 0);
      chk("t6_auto_owner", a_st_own[4], 0);
      chk("t6_next_wrap", a_st_t[5], t0 + 5 * IVL + 1);
      chk("t6_done_count", a_done_t.size(), 1);
      chk("t6_done_who", a_done_who[0], 1);
      chk("t6_done_time", a_done_t[0], a_fall_t[3] + 1);
    end else begin
      chk("t5_events_present", 0, 1);
    end
    chk("t5_no_err", a_err_t.size(), 0);
    chk("a_protocol_violations", a_viol, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
